// File: rtl/sd_cmd_tx_if.sv
// Command-side bus of the SPI-mode SD command transmitter.
// The controller drives request fields and the SCLK falling-edge strobe.
interface sd_cmd_tx_if;
  logic        start;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic        sclkEn;
  logic        DI;
  logic        csN;
  logic        busy;
  logic        isCmdFinish;

  modport master (
    output start, cmd, arg, sclkEn,
    input  DI, csN, busy, isCmdFinish
  );

  modport slave (
    input  start, cmd, arg, sclkEn,
    output DI, csN, busy, isCmdFinish
  );
endinterface

// File: rtl/sd_cmd_tx.sv
// SPI-mode SD command transmitter: shifts a 48-bit command frame out on DI,
// framed by idle ones, one bit per SCLK falling-edge strobe.
module sd_cmd_tx #(
  parameter int PRE_BITS  = 8,
  parameter int POST_BITS = 8
) (
  input  logic         clk,
  input  logic         reset,
  sd_cmd_tx_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, PRE, FRAME, POST, FIN} state_t;

  localparam logic [7:0] PRE_LAST   = 8'(PRE_BITS - 1);
  localparam logic [7:0] POST_LAST  = 8'(POST_BITS - 1);
  localparam logic [7:0] FRAME_LAST = 8'd47;

  state_t      r_state;
  logic [7:0]  r_bitCnt;
  logic [47:0] r_frame;
  logic        r_di;
  logic        r_csN;
  logic        r_busy;
  logic        r_finish;

  logic [39:0] w_crcMsg;
  logic [6:0]  w_crc;
  logic [47:0] w_loadFrame;

  // CRC7 (x^7 + x^3 + 1) over the 40 header bits, MSB first, computed at load.
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign w_crcMsg    = {2'b01, bus.cmd, bus.arg};
  assign w_crc       = crc7(w_crcMsg);
  assign w_loadFrame = {w_crcMsg, w_crc, 1'b1};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_bitCnt <= 8'd0;
      r_frame  <= 48'd0;
      r_di     <= 1'b1;
      r_csN    <= 1'b1;
      r_busy   <= 1'b0;
      r_finish <= 1'b0;
    end else begin
      r_finish <= 1'b0;
      case (r_state)
        IDLE: begin
          r_di     <= 1'b1;
          r_csN    <= 1'b1;
          r_busy   <= 1'b0;
          r_bitCnt <= 8'd0;
          if (bus.start) begin
            r_frame <= w_loadFrame;
            r_busy  <= 1'b1;
            r_csN   <= 1'b0;
            r_state <= (PRE_BITS == 0) ? FRAME : PRE;
          end
        end
        PRE: begin
          if (bus.sclkEn) begin
            r_di <= 1'b1;
            if (r_bitCnt == PRE_LAST) begin
              r_bitCnt <= 8'd0;
              r_state  <= FRAME;
            end else begin
              r_bitCnt <= r_bitCnt + 8'd1;
            end
          end
        end
        FRAME: begin
          if (bus.sclkEn) begin
            r_di    <= r_frame[47];
            r_frame <= {r_frame[46:0], 1'b0};
            if (r_bitCnt == FRAME_LAST) begin
              r_bitCnt <= 8'd0;
              r_state  <= (POST_BITS == 0) ? FIN : POST;
            end else begin
              r_bitCnt <= r_bitCnt + 8'd1;
            end
          end
        end
        POST: begin
          if (bus.sclkEn) begin
            r_di <= 1'b1;
            if (r_bitCnt == POST_LAST) begin
              r_bitCnt <= 8'd0;
              r_state  <= FIN;
            end else begin
              r_bitCnt <= r_bitCnt + 8'd1;
            end
          end
        end
        FIN: begin
          // One extra strobe so the final bit is held for a full SCLK period.
          if (bus.sclkEn) begin
            r_finish <= 1'b1;
            r_busy   <= 1'b0;
            r_csN    <= 1'b1;
            r_di     <= 1'b1;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.DI          = r_di;
  assign bus.csN         = r_csN;
  assign bus.busy        = r_busy;
  assign bus.isCmdFinish = r_finish;

endmodule

// File: tb/tb_sd_cmd_tx.sv
// Directed-plus-random bench for sd_cmd_tx; expected DI streams come from a
// polynomial long-division model of the command frame.
module tb_sd_cmd_tx;

  localparam int PRE_BITS  = 8;
  localparam int POST_BITS = 8;
  localparam int NSTROBE   = PRE_BITS + 48 + POST_BITS + 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sd_cmd_tx_if bus();

  sd_cmd_tx #(.PRE_BITS(PRE_BITS), .POST_BITS(POST_BITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int total = 0;
  int bad   = 0;

  logic cap [0:255];
  int   capN, finishCnt, finishAt, negCnt, busyCnt;
  bit   glitch, csHigh;
  logic lastDI;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Remainder of (header * x^7) modulo x^7 + x^3 + 1 by long division.
  function automatic logic [6:0] refCrc(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'd0};
    for (int b = 46; b >= 7; b--)
      if (r[b]) r = r ^ (47'h89 << (b - 7));
    return r[6:0];
  endfunction

  function automatic logic [47:0] refFrame(input logic [5:0] c, input logic [31:0] a);
    return {2'b01, c, a, refCrc({2'b01, c, a}), 1'b1};
  endfunction

  task automatic observe(input int k, input bit isLast);
    negCnt++;
    if (bus.busy === 1'b1) busyCnt++;
    if (bus.isCmdFinish === 1'b1) begin
      finishCnt++;
      finishAt = k;
    end
    if (!isLast && bus.csN !== 1'b0) csHigh = 1'b1;
  endtask

  task automatic applyStimulus(input logic [5:0] c, input logic [31:0] a,
                               input bit hold, input bit strobeNow);
    bus.cmd    = c;
    bus.arg    = a;
    bus.start  = 1'b1;
    bus.sclkEn = strobeNow;
    @(negedge clk);
    if (!hold) bus.start = 1'b0;
    bus.sclkEn = 1'b0;
    checkOutput("acceptBusy", 64'(bus.busy), 64'd1);
    checkOutput("acceptCsN", 64'(bus.csN), 64'd0);
    checkOutput("acceptDI", 64'(bus.DI), 64'd1);
    capN = 0; finishCnt = 0; finishAt = -1; negCnt = 1; busyCnt = 1;
    glitch = 1'b0; csHigh = 1'b0; lastDI = 1'b1;
  endtask

  task automatic streamStrobes(input int n, input int minGap, input int maxGap, input int injectAt);
    int gap;
    for (int k = 1; k <= n; k++) begin
      gap = $urandom_range(maxGap, minGap);
      repeat (gap) begin
        bus.sclkEn = 1'b0;
        @(negedge clk);
        observe(k - 1, 1'b0);
        if (bus.DI !== lastDI) glitch = 1'b1;
      end
      if (k == injectAt) begin
        bus.start = 1'b1;
        bus.cmd   = 6'($urandom);
        bus.arg   = $urandom;
      end
      bus.sclkEn = 1'b1;
      @(negedge clk);
      if (k == injectAt) bus.start = 1'b0;
      cap[capN] = bus.DI;
      capN++;
      lastDI = bus.DI;
      observe(k, k == NSTROBE);
    end
    bus.sclkEn = 1'b0;
  endtask

  task automatic checkCommand(input string tag, input logic [5:0] c, input logic [31:0] a);
    logic [47:0] frame;
    int ones;
    frame = '0;
    ones  = 0;
    for (int i = 0; i < 48; i++) frame = {frame[46:0], cap[PRE_BITS + i]};
    for (int i = 0; i < NSTROBE; i++)
      if ((i < PRE_BITS || i >= PRE_BITS + 48) && cap[i] === 1'b1) ones++;
    checkOutput({tag, ".frame"}, 64'(frame), 64'(refFrame(c, a)));
    checkOutput({tag, ".padOnes"}, 64'(ones), 64'(PRE_BITS + POST_BITS + 1));
    checkOutput({tag, ".finishCnt"}, 64'(finishCnt), 64'd1);
    checkOutput({tag, ".finishAt"}, 64'(finishAt), 64'(NSTROBE));
    checkOutput({tag, ".diGlitch"}, 64'(glitch), 64'd0);
    checkOutput({tag, ".csNLow"}, 64'(csHigh), 64'd0);
    checkOutput({tag, ".busyCycles"}, 64'(busyCnt), 64'(negCnt - 1));
    checkOutput({tag, ".endCsN"}, 64'(bus.csN), 64'd1);
    checkOutput({tag, ".endBusy"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    logic [47:0] f;
    logic [5:0]  c;
    logic [31:0] a;
    bit sawFinish;

    reset = 1'b1;
    bus.start = 1'b0; bus.cmd = '0; bus.arg = '0; bus.sclkEn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("rstDI", 64'(bus.DI), 64'd1);
    checkOutput("rstCsN", 64'(bus.csN), 64'd1);
    checkOutput("rstBusy", 64'(bus.busy), 64'd0);
    checkOutput("rstFinish", 64'(bus.isCmdFinish), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // CMD0 with a strobe every 4 clocks.
    applyStimulus(6'd0, 32'd0, 1'b0, 1'b0);
    streamStrobes(NSTROBE, 3, 3, -1);
    checkCommand("cmd0", 6'd0, 32'd0);
    for (int i = 0; i < 48; i++) f = {f[46:0], cap[PRE_BITS + i]};
    checkOutput("cmd0Bytes", 64'(f), 64'h4000_0000_0095);
    @(negedge clk);

    // CMD8 with sclkEn held high, including the acceptance cycle.
    applyStimulus(6'd8, 32'h0000_01AA, 1'b0, 1'b1);
    streamStrobes(NSTROBE, 0, 0, -1);
    checkCommand("cmd8", 6'd8, 32'h0000_01AA);
    for (int i = 0; i < 48; i++) f = {f[46:0], cap[PRE_BITS + i]};
    checkOutput("cmd8Bytes", 64'(f), 64'h4800_0001_AA87);
    checkOutput("cmd8BusyClks", 64'(busyCnt), 64'(NSTROBE));
    @(negedge clk);

    // CMD17 with irregular strobe spacing of 1..9 clocks.
    applyStimulus(6'd17, 32'h0000_0200, 1'b0, 1'b0);
    streamStrobes(NSTROBE, 0, 8, -1);
    checkCommand("cmd17", 6'd17, 32'h0000_0200);
    for (int i = 0; i < 48; i++) f = {f[46:0], cap[PRE_BITS + i]};
    checkOutput("cmd17Header", 64'(f[47:8]), 64'h51_0000_0200);
    @(negedge clk);

    // Stray start with new cmd/arg in the middle of the frame.
    c = 6'($urandom); a = $urandom;
    applyStimulus(c, a, 1'b0, 1'b0);
    streamStrobes(NSTROBE, 0, 2, PRE_BITS + 10);
    checkCommand("midStart", c, a);
    @(negedge clk);

    // Asynchronous abort after 20 frame bits.
    applyStimulus(6'($urandom), $urandom, 1'b0, 1'b0);
    streamStrobes(PRE_BITS + 20, 0, 1, -1);
    #2 reset = 1'b1;
    #1;
    checkOutput("abortDI", 64'(bus.DI), 64'd1);
    checkOutput("abortCsN", 64'(bus.csN), 64'd0 + 64'd1);
    checkOutput("abortBusy", 64'(bus.busy), 64'd0);
    sawFinish = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (bus.isCmdFinish !== 1'b0) sawFinish = 1'b1;
    end
    reset = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (bus.isCmdFinish !== 1'b0) sawFinish = 1'b1;
    end
    checkOutput("abortNoFinish", 64'(sawFinish), 64'd0);
    c = 6'($urandom); a = $urandom;
    applyStimulus(c, a, 1'b0, 1'b0);
    streamStrobes(NSTROBE, 0, 3, -1);
    checkCommand("postAbort", c, a);
    @(negedge clk);

    // Start held high through finish: back-to-back commands.
    c = 6'($urandom); a = $urandom;
    applyStimulus(c, a, 1'b1, 1'b0);
    bus.cmd = 6'd41; bus.arg = 32'h4000_0000;
    streamStrobes(NSTROBE, 0, 1, -1);
    checkCommand("b2bFirst", c, a);
    @(negedge clk);
    checkOutput("b2bCsNGap", 64'(bus.csN), 64'd0);
    checkOutput("b2bBusy", 64'(bus.busy), 64'd1);
    bus.start = 1'b0;
    capN = 0; finishCnt = 0; finishAt = -1; negCnt = 1; busyCnt = 1;
    glitch = 1'b0; csHigh = 1'b0; lastDI = 1'b1;
    streamStrobes(NSTROBE, 0, 1, -1);
    checkCommand("b2bSecond", 6'd41, 32'h4000_0000);
    @(negedge clk);

    // A few fully random commands.
    for (int t = 0; t < 3; t++) begin
      c = 6'($urandom); a = $urandom;
      applyStimulus(c, a, 1'b0, 1'($urandom));
      streamStrobes(NSTROBE, 0, 4, -1);
      checkCommand("random", c, a);
      @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
